// File: rtl/reg_in_fifo.sv
// Input-port receive stage: valid/ready producer side feeding a small FIFO that
// delivers one word per IN instruction into stage x2. Optional macro REG_IN_BYPASS_EN.
module reg_in_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              datainv,
  output logic              datainrdy,
  input  logic              rdreqx1,
  input  logic              stalled,
  output logic [DATA_W-1:0] datainx2,
  output logic              datainvx2,
  output logic              starvex2,
  output logic [ADDR_W:0]   levelx
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_next;
  logic              push, pop_req, pop, bypass, wr_en, empty;

  always_comb begin
    empty   = (count == '0);
    push    = datainv && datainrdy;
    pop_req = rdreqx1 && !stalled;
    pop     = pop_req && !empty;
`ifdef REG_IN_BYPASS_EN
    // Empty FIFO with a coinciding push and request: forward datain, skip the write.
    bypass  = pop_req && empty && push;
`else
    bypass  = 1'b0;
`endif
    wr_en   = push && !bypass;
    unique case ({wr_en, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      datainrdy <= 1'b0;
      datainx2  <= '0;
      datainvx2 <= 1'b0;
      starvex2  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_next;
      datainrdy <= (count_next < CNT_FULL);
      // While stalled all x2 outputs freeze; pop is already blocked via pop_req.
      if (!stalled) begin
        datainvx2 <= pop || bypass;
        starvex2  <= pop_req && !pop && !bypass;
        if (pop)         datainx2 <= mem[rd_ptr];
        else if (bypass) datainx2 <= datain;
      end
    end
  end

  assign levelx = count;

endmodule

// File: tb/tb_reg_in_fifo.sv
// Directed bench for reg_in_fifo: a queue scoreboard holds pushed words and
// predicts each delivery; every output is compared after each clock edge.
module tb_reg_in_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] datain = '0;
  logic              datainv = 1'b0;
  logic              datainrdy;
  logic              rdreqx1 = 1'b0;
  logic              stalled = 1'b0;
  logic [DATA_W-1:0] datainx2;
  logic              datainvx2;
  logic              starvex2;
  logic [ADDR_W:0]   levelx;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_v = 1'b0, exp_st = 1'b0, exp_rdy = 1'b0;

  reg_in_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .datain(datain), .datainv(datainv),
    .datainrdy(datainrdy), .rdreqx1(rdreqx1), .stalled(stalled),
    .datainx2(datainx2), .datainvx2(datainvx2), .starvex2(starvex2),
    .levelx(levelx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(datainx2),  32'(exp_data));
    check({tag, ".valid"}, 32'(datainvx2), 32'(exp_v));
    check({tag, ".starve"},32'(starvex2),  32'(exp_st));
    check({tag, ".level"}, 32'(levelx),    32'(sb_q.size()));
    check({tag, ".rdy"},   32'(datainrdy), 32'(exp_rdy));
  endtask

  // One cycle: predict from the scoreboard, drive, clock, compare.
  task automatic step(input string tag, input logic push, input logic [DATA_W-1:0] word,
                      input logic req, input logic stall);
    logic push_ok, pop_req, byp;
    push_ok = push && exp_rdy;
    pop_req = req && !stall;
`ifdef REG_IN_BYPASS_EN
    byp = pop_req && push_ok && (sb_q.size() == 0);
`else
    byp = 1'b0;
`endif
    if (pop_req) begin
      if (sb_q.size() > 0) begin
        exp_data = sb_q.pop_front(); exp_v = 1'b1; exp_st = 1'b0;
      end else if (byp) begin
        exp_data = word; exp_v = 1'b1; exp_st = 1'b0;
      end else begin
        exp_v = 1'b0; exp_st = 1'b1;
      end
    end else if (!stall) begin
      exp_v = 1'b0; exp_st = 1'b0;
    end
    if (push_ok && !byp) sb_q.push_back(word);
    exp_rdy = (sb_q.size() < DEPTH);
    datainv = push; datain = word; rdreqx1 = req; stalled = stall;
    @(posedge clock); #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_data = '0; exp_v = 1'b0; exp_st = 1'b0; exp_rdy = 1'b0;
  endtask

  initial begin
    // 1. reset held for 3 cycles
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_all("reset");
    end
    reset_n = 1'b1;
    step("post_reset", 1'b0, '0, 1'b0, 1'b0);
    check("post_reset.rdy_const", 32'(datainrdy), 32'd1);

    // 2. fill to full, then an ignored fifth push
    step("fill0", 1'b1, 16'h0011, 1'b0, 1'b0);
    step("fill1", 1'b1, 16'h0022, 1'b0, 1'b0);
    step("fill2", 1'b1, 16'h0033, 1'b0, 1'b0);
    step("fill3", 1'b1, 16'h0044, 1'b0, 1'b0);
    check("full.level_const", 32'(levelx), 32'd4);
    check("full.rdy_const", 32'(datainrdy), 32'd0);
    step("fill_over", 1'b1, 16'h0055, 1'b0, 1'b0);
    check("over.level_const", 32'(levelx), 32'd4);

    // 3. drain in order, then starve
    step("drain0", 1'b0, '0, 1'b1, 1'b0);
    check("drain0.data_const", 32'(datainx2), 32'h0011);
    step("drain1", 1'b0, '0, 1'b1, 1'b0);
    step("drain2", 1'b0, '0, 1'b1, 1'b0);
    step("drain3", 1'b0, '0, 1'b1, 1'b0);
    check("drain3.data_const", 32'(datainx2), 32'h0044);
    step("starve", 1'b0, '0, 1'b1, 1'b0);
    check("starve.flag_const", 32'(starvex2), 32'd1);
    check("starve.hold_const", 32'(datainx2), 32'h0044);
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    // 4. stall hold with a push under stall
    step("aa_push", 1'b1, 16'h00AA, 1'b0, 1'b0);
    step("aa_pop", 1'b0, '0, 1'b1, 1'b0);
    step("stall0", 1'b1, 16'h00BB, 1'b1, 1'b1);
    step("stall1", 1'b0, '0, 1'b1, 1'b1);
    step("stall2", 1'b0, '0, 1'b1, 1'b1);
    check("stall.data_const", 32'(datainx2), 32'h00AA);
    check("stall.valid_const", 32'(datainvx2), 32'd1);
    check("stall.level_const", 32'(levelx), 32'd1);
    step("bb_pop", 1'b0, '0, 1'b1, 1'b0);
    check("bb.data_const", 32'(datainx2), 32'h00BB);

    // 5. concurrent push/pop at level 2 across pointer wrap
    step("pre0", 1'b1, 16'h0100, 1'b0, 1'b0);
    step("pre1", 1'b1, 16'h0101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("wrap", 1'b1, 16'(16'h0102 + i), 1'b1, 1'b0);
      check("wrap.level_const", 32'(levelx), 32'd2);
      check("wrap.order", 32'(datainx2), 32'(16'h0100 + i));
    end
    step("wdrain0", 1'b0, '0, 1'b1, 1'b0);
    step("wdrain1", 1'b0, '0, 1'b1, 1'b0);
    step("wempty", 1'b0, '0, 1'b0, 1'b0);

    // 6. empty with coinciding push and request
    step("coinc", 1'b1, 16'h0077, 1'b1, 1'b0);
`ifdef REG_IN_BYPASS_EN
    check("coinc.data_const", 32'(datainx2), 32'h0077);
    check("coinc.valid_const", 32'(datainvx2), 32'd1);
    check("coinc.level_const", 32'(levelx), 32'd0);
`else
    check("coinc.starve_const", 32'(starvex2), 32'd1);
    check("coinc.level_const", 32'(levelx), 32'd1);
    step("coinc_pop", 1'b0, '0, 1'b1, 1'b0);
    check("coinc_pop.data_const", 32'(datainx2), 32'h0077);
`endif

    // asynchronous reset mid-fill
    step("mf0", 1'b1, 16'h0301, 1'b0, 1'b0);
    step("mf1", 1'b1, 16'h0302, 1'b0, 1'b0);
    step("mf2", 1'b1, 16'h0303, 1'b0, 1'b0);
    check("midfill.level_const", 32'(levelx), 32'd3);
    datainv = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async.level", 32'(levelx), 32'd0);
    check_all("async");
    @(posedge clock); #1;
    reset_n = 1'b1;
    step("after_async", 1'b0, '0, 1'b0, 1'b0);
    step("after_async_push", 1'b1, 16'h0400, 1'b0, 1'b0);
    step("after_async_pop", 1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_in_fifo.md
Name: reg_in_fifo

Overview:
- Input-port stage of the pipelined microcontroller, the receive-side counterpart of the output register stage.
- Accepts words from an external producer over a valid/ready handshake and buffers them in a small FIFO.
- Delivers one word per IN instruction into the x2 pipeline stage, honouring pipeline stall.
- Reports starvation, so the pipeline sees when an IN found no data.

Parameters:
- DATA_W, 16, width of one data word (matches t_data).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), pointer width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- datain  in  DATA_W  external input word.
- datainv  in  1  external word valid.
- datainrdy  out  1  FIFO can accept a word (registered).
- rdreqx1  in  1  IN instruction in stage x1 requests a word.
- stalled  in  1  pipeline stall; freezes x2 outputs and blocks pop.
- datainx2  out  DATA_W  delivered word, stage x2.
- datainvx2  out  1  datainx2 valid this cycle.
- starvex2  out  1  previous request found FIFO empty.
- levelx  out  ADDR_W+1  current FIFO occupancy 0..DEPTH.

Behaviour:
- Reset, asynchronous on reset_n low:
  - pointers = 0, count = 0, datainrdy = 0.
  - datainx2 = 0, datainvx2 = 0, starvex2 = 0.
  - Mid-operation reset discards all buffered data immediately.
- Ready:
  - datainrdy is a register loaded each edge with (count_next < DEPTH).
  - It is 0 while in reset and 1 on the first edge after reset_n rises.
- Push: datainv && datainrdy. Writes datain at wr_ptr; wr_ptr increments mod DEPTH (natural wrap).
  - datainv while datainrdy = 0 is ignored; the producer must hold the word.
- Pop request: rdreqx1 && !stalled.
  - count > 0:
    - mem[rd_ptr] loads into datainx2; datainvx2 = 1; starvex2 = 0.
    - rd_ptr increments mod DEPTH.
  - count == 0:
    - datainx2 holds its value; datainvx2 = 0; starvex2 = 1 (one cycle per request).
- No request and !stalled: datainvx2 = 0, starvex2 = 0, datainx2 holds.
- stalled = 1:
  - datainx2, datainvx2 and starvex2 all hold their previous values.
  - No pop occurs; a push may still occur.
- Latency:
  - Pop data appears on the edge following the request (1 cycle).
  - A pushed word is poppable one cycle after the push edge.
- Simultaneous push and pop with count > 0: count unchanged, both pointers advance.
- Simultaneous push and pop with count == 0 (no bypass): the pop starves and the pushed word stays in the FIFO.
- Full: count == DEPTH, so datainrdy = 0 on the next edge. A pop in the full cycle frees a slot, so datainrdy = 1 on that edge.
- levelx = count (registered).
- Count arithmetic is ADDR_W+1 bits; it never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: REG_IN_BYPASS_EN.
- Defined: when count == 0 and a push and a pop request coincide (not stalled):
  - datain goes straight to datainx2 with datainvx2 = 1 and starvex2 = 0.
  - The FIFO is not written; count stays 0.
- Undefined: no bypass; behaviour exactly as in Behaviour (starve, word buffered).

Test Plan:
1. Reset check: hold reset_n = 0 for 3 cycles, then release.
   - During reset: all outputs 0.
   - After release: datainrdy = 1 on the first edge, levelx = 0.
2. Fill to full: push 0x0011, 0x0022, 0x0033, 0x0044 with no requests.
   - levelx reaches 4 and datainrdy = 0.
   - A fifth push of 0x0055 is ignored; levelx stays 4.
3. Drain in order: after scenario 2, assert rdreqx1 for 4 cycles.
   - datainx2 = 0x0011, 0x0022, 0x0033, 0x0044 with datainvx2 = 1 each cycle.
   - Fifth request: datainvx2 = 0, starvex2 = 1, datainx2 holds 0x0044.
4. Stall hold: deliver 0x00AA, then assert stalled for 3 cycles with rdreqx1 = 1 and a pushed word 0x00BB.
   - datainx2 = 0x00AA, datainvx2 = 1 held throughout; levelx goes 0 to 1.
   - After stall release: next request delivers 0x00BB.
5. Wrap and concurrent push/pop: run 10 cycles of push+pop at levelx = 2 with sequential values 0x0100..0x0109.
   - levelx stays 2 and output order is preserved across pointer wrap.
6. Empty with simultaneous push+request of 0x0077:
   - Without REG_IN_BYPASS_EN: starvex2 = 1, levelx = 1.
   - With REG_IN_BYPASS_EN: datainx2 = 0x0077, datainvx2 = 1, levelx = 0.
   - Also apply reset_n low mid-fill with levelx = 3: levelx = 0 immediately (asynchronous).
